serializer: RTL and testbench

- Parallel-to-serial converter for the systolic datapath. It is the transmit-side counterpart of the shift-in accumulator.
- Accepts one packed vector of N words of NUM_BITS each over a valid/ready handshake, then emits the words one per beat on a valid/ready stream.
- Word order is chosen so that a downstream shift-in accumulator reconstructs the original vector bit-exactly after N beats.

---
 rtl/serializer.sv | 76 +++++++
 tb/tb_serializer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// Parallel-to-serial converter: one N-word vector in, N words out, word 0 first.
// Feeds a shift-in accumulator that rebuilds the vector after N beats.
module serializer #(
    parameter int NUM_BITS = 8,
    parameter int N        = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N*NUM_BITS-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [NUM_BITS-1:0]   C_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o
);

    localparam int W  = N * NUM_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   count_q;
    logic [W-1:0]    shreg_q;

    logic            last_w;
    logic            xfer_w;

    assign last_w  = (count_q == CW'(N - 1));
    assign xfer_w  = (state_q == SEND) && ready_i;
    // Accepting on the final beat keeps back-to-back vectors bubble-free.
    assign ready_o = (state_q == IDLE) || (xfer_w && last_w);

    assign valid_o = (state_q == SEND);
    assign last_o  = (state_q == SEND) && last_w;
    assign C_o     = shreg_q[NUM_BITS-1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            count_q <= '0;
            shreg_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        shreg_q <= data_i;
                        count_q <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (xfer_w) begin
                        if (!last_w) begin
                            shreg_q <= shreg_q >> NUM_BITS;
                            count_q <= count_q + CW'(1);
                        end else if (valid_i) begin
                            shreg_q <= data_i;
                            count_q <= '0;
                        end else begin
                            shreg_q <= '0;
                            count_q <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: scoreboard of expected words, stall and
// round-trip checks against a shift-in accumulator model.
module tb_serializer;

    localparam int NB = 8;
    localparam int N  = 4;

    logic          clk_i;
    logic          rst_ni;
    logic [31:0]   data_i;
    logic          valid_i;
    logic          ready_o;
    logic [NB-1:0] C_o;
    logic          valid_o;
    logic          ready_i;
    logic          last_o;

    serializer #(.NUM_BITS(NB), .N(N)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .C_o     (C_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .last_o  (last_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int npass = 0;
    int nfail = 0;
    int ntotal = 0;

    logic [8:0]  sb_q[$];
    int          xfer_n = 0;
    logic [31:0] acc = '0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_c = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_vec(input logic [31:0] d);
        logic [31:0] v;
        v = d;
        for (int k = 0; k < N; k++)
            sb_q.push_back({(k == N - 1), v[k*NB +: NB]});
    endtask

    // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic load(input logic [31:0] d);
        int n;
        valid_i = 1'b1;
        data_i  = d;
        n = 0;
        @(negedge clk_i);
        while (!ready_o && n < 50) begin
            n++;
            @(negedge clk_i);
        end
        chk("load_accept", 32'(ready_o), 32'd1);
        push_vec(d);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
        @(negedge clk_i);
        chk("drain_idle", 32'(valid_o), 32'd0);
    endtask

    // Monitor: pop scoreboard on each transfer, verify stalls hold.
    always @(negedge clk_i) begin
        logic [8:0] e;
        if (rst_ni) begin
            if (prev_stall) begin
                chk("stall_valid", 32'(valid_o), 32'd1);
                chk("stall_hold", 32'(C_o), 32'(prev_c));
            end
            if (valid_o && ready_i) begin
                xfer_n++;
                acc = {C_o, acc[31:NB]};
                if (sb_q.size() == 0) begin
                    chk("unexpected_word", 32'(C_o), 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("word", 32'(C_o), 32'(e[7:0]));
                    chk("last", 32'(last_o), 32'(e[8]));
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_c     = C_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int x0;
        logic [0:6] pat;

        rst_ni  = 1'b0;
        valid_i = 1'b1;
        data_i  = 32'hDEADBEEF;
        ready_i = 1'b1;

        repeat (3) begin
            @(negedge clk_i);
            chk("rst_valid", 32'(valid_o), 32'd0);
            chk("rst_C", 32'(C_o), 32'd0);
            chk("rst_last", 32'(last_o), 32'd0);
        end
        @(posedge clk_i);
        #1;
        rst_ni  = 1'b1;
        valid_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_idle_valid", 32'(valid_o), 32'd0);
        @(posedge clk_i);
        #1;

        // Single vector, full throughput.
        load(32'h44332211);
        for (int i = 0; i < N; i++) begin
            @(negedge clk_i);
            chk("single_valid", 32'(valid_o), 32'd1);
            chk("single_ready", 32'(ready_o), 32'(i == N - 1));
        end
        @(negedge clk_i);
        chk("single_idle", 32'(valid_o), 32'd0);
        chk("single_empty", 32'(sb_q.size()), 32'd0);
        @(posedge clk_i);
        #1;

        // Backpressure.
        x0 = xfer_n;
        load(32'h44332211);
        pat = 7'b1001011;
        for (int i = 0; i < 7; i++) begin
            ready_i = pat[i];
            @(posedge clk_i);
            #1;
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp_xfers", 32'(xfer_n - x0), 32'd4);
        chk("bp_idle", 32'(valid_o), 32'd0);
        @(posedge clk_i);
        #1;

        // Back-to-back vectors, no bubble.
        x0 = xfer_n;
        load(32'h44332211);
        valid_i = 1'b1;
        data_i  = 32'h88776655;
        for (int i = 0; i < N; i++) begin
            @(negedge clk_i);
            chk("b2b_valid1", 32'(valid_o), 32'd1);
            chk("b2b_ready", 32'(ready_o), 32'(i == N - 1));
        end
        chk("b2b_accept_on_44", 32'(C_o), 32'h44);
        push_vec(32'h88776655);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk_i);
            chk("b2b_valid2", 32'(valid_o), 32'd1);
        end
        drain();
        chk("b2b_xfers", 32'(xfer_n - x0), 32'd8);
        @(posedge clk_i);
        #1;

        // Reset mid-transfer.
        load(32'h44332211);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("mid_C22", 32'(C_o), 32'h22);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        sb_q.delete();
        @(negedge clk_i);
        chk("mid_valid", 32'(valid_o), 32'd0);
        chk("mid_C", 32'(C_o), 32'd0);
        chk("mid_ready", 32'(ready_o), 32'd1);
        repeat (3) begin
            @(negedge clk_i);
            chk("mid_quiet", 32'(valid_o), 32'd0);
        end
        @(posedge clk_i);
        #1;

        // Round trip through accumulator model, with a stall.
        x0 = xfer_n;
        load(32'hA1B2C3D4);
        ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        drain();
        chk("rt_xfers", 32'(xfer_n - x0), 32'd4);
        chk("rt_product", acc, 32'hA1B2C3D4);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
